// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter for the 5-stage core.
// Picks the next PC each cycle from the sequential, jump and branch sources.
// Raises IF/ID and ID/EX squashes on redirects and sequences BOOT/RUN/HALT.
// Also keeps saturating branch and taken counters for the debug register file.
module pc_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jt_i,
    input  logic              branch_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] bt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic              fetch_valid_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  taken_cnt_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_valid_q, halted_q;
    logic [CNT_W-1:0]  bcnt_q, tcnt_q;
    logic              run, take_br, do_halt, do_jump;

    // Next-PC selection; a taken branch in EX outranks everything younger.
    always_comb begin
        run     = (state_q == RUN);
        take_br = run & branch_i & branch_taken_i;
        do_halt = run & ~take_br & halt_i & ~stall_i;
        do_jump = run & ~take_br & ~halt_i & jump_i & ~stall_i;
        pc_d    = pc_q;
        if (take_br)
            pc_d = bt_i;
        else if (do_jump)
            pc_d = jt_i;
        else if (run & ~halt_i & ~stall_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    // State, PC, registered status outputs and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            bcnt_q        <= '0;
            tcnt_q        <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    pc_q <= pc_d;
                    // EX keeps moving during load-use stalls, so stall does not gate counting
                    if (branch_i && bcnt_q != CNT_MAX)
                        bcnt_q <= bcnt_q + CNT_W'(1);
                    if (branch_i && branch_taken_i && tcnt_q != CNT_MAX)
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    if (do_halt) begin
                        state_q       <= HALT;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end
                end
                HALT: begin
                    // frozen until reset
                end
                default: begin
                    state_q       <= BOOT;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    // Flushes follow the current inputs but only while running.
    always_comb begin
        flush_ifid_o = take_br | do_jump;
        flush_idex_o = take_br;
    end

    assign pc_o          = pc_q;
    assign pc_plus1_o    = pc_q + ADDR_W'(1);
    assign fetch_valid_o = fetch_valid_q;
    assign halted_o      = halted_q;
    assign branch_cnt_o  = bcnt_q;
    assign taken_cnt_o   = tcnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes hand-computed expectations
// for each cycle, a monitor pops and compares them on the falling edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 0, halt_i = 0, jump_i = 0, branch_i = 0, branch_taken_i = 0;
    logic [7:0]  jt_i = '0, bt_i = '0;
    logic [7:0]  pc_o, pc_plus1_o;
    logic        fetch_valid_o, flush_ifid_o, flush_idex_o, halted_o;
    logic [15:0] branch_cnt_o, taken_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        logic [7:0]  pc, pcp1;
        logic        fv, fi, fx, h;
        logic [15:0] bc, tc;
    } exp_t;

    exp_t q[$];

    pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .halt_i(halt_i),
        .jump_i(jump_i), .jt_i(jt_i), .branch_i(branch_i),
        .branch_taken_i(branch_taken_i), .bt_i(bt_i), .pc_o(pc_o),
        .pc_plus1_o(pc_plus1_o), .fetch_valid_o(fetch_valid_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .halted_o(halted_o), .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge.
    task automatic drv(input logic r, st, hl, jp, input logic [7:0] jt,
                       input logic br, tk, input logic [7:0] bt);
        @(posedge clk);
        #1;
        rst_n = r; stall_i = st; halt_i = hl; jump_i = jp; jt_i = jt;
        branch_i = br; branch_taken_i = tk; bt_i = bt;
    endtask

    // Drive a cycle and queue what the outputs must show during it.
    task automatic cyc(input string nm, input logic r, st, hl, jp, input logic [7:0] jt,
                       input logic br, tk, input logic [7:0] bt,
                       input logic [7:0] epc, input logic efv, efi, efx, eh,
                       input logic [15:0] ebc, etc_);
        exp_t e;
        drv(r, st, hl, jp, jt, br, tk, bt);
        e.nm = nm; e.pc = epc; e.pcp1 = epc + 8'd1; e.fv = efv; e.fi = efi;
        e.fx = efx; e.h = eh; e.bc = ebc; e.tc = etc_;
        q.push_back(e);
    endtask

    // Monitor: compare queued expectations mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (pc_o !== e.pc || pc_plus1_o !== e.pcp1 || fetch_valid_o !== e.fv ||
                    flush_ifid_o !== e.fi || flush_idex_o !== e.fx || halted_o !== e.h ||
                    branch_cnt_o !== e.bc || taken_cnt_o !== e.tc) begin
                    bad++;
                    $display("FAIL %s: got pc=%h p1=%h fv=%b fi=%b fx=%b h=%b bc=%h tc=%h want pc=%h p1=%h fv=%b fi=%b fx=%b h=%b bc=%h tc=%h",
                             e.nm, pc_o, pc_plus1_o, fetch_valid_o, flush_ifid_o, flush_idex_o,
                             halted_o, branch_cnt_o, taken_cnt_o, e.pc, e.pcp1, e.fv, e.fi,
                             e.fx, e.h, e.bc, e.tc);
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        //   name        r st hl jp jt     br tk bt     pc    fv fi fx h  bc        tc
        // reset: inputs active but flushes must stay low
        cyc("reset",     0, 1, 1, 1, 8'h11, 1, 1, 8'h22, 8'h00, 0, 0, 0, 0, 16'h0, 16'h0);
        // BOOT ignores a taken branch
        cyc("boot",      1, 0, 0, 0, 8'h00, 1, 1, 8'h55, 8'h00, 0, 0, 0, 0, 16'h0, 16'h0);
        cyc("run0",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0, 16'h0);
        cyc("run1",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0, 16'h0, 16'h0);
        cyc("run2",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 16'h0, 16'h0);
        cyc("run3",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h03, 1, 0, 0, 0, 16'h0, 16'h0);
        // jump to 10, then taken branch with stall/jump/halt all present
        cyc("jmp10",     1, 0, 0, 1, 8'h10, 0, 0, 8'h00, 8'h04, 1, 1, 0, 0, 16'h0, 16'h0);
        cyc("br34",      1, 1, 1, 1, 8'h66, 1, 1, 8'h34, 8'h10, 1, 1, 1, 0, 16'h0, 16'h0);
        cyc("at34",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h34, 1, 0, 0, 0, 16'h1, 16'h1);
        // jump chain and 3-cycle stall; jump/halt under stall are held off
        cyc("jmp20",     1, 0, 0, 1, 8'h20, 0, 0, 8'h00, 8'h35, 1, 1, 0, 0, 16'h1, 16'h1);
        cyc("jmp7f",     1, 0, 0, 1, 8'h7F, 0, 0, 8'h00, 8'h20, 1, 1, 0, 0, 16'h1, 16'h1);
        cyc("at7f",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h7F, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("stall1",    1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h80, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("stall_jmp", 1, 1, 0, 1, 8'hAA, 0, 0, 8'h00, 8'h80, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("stall_hlt", 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h80, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("unstall",   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h80, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("at81",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h81, 1, 0, 0, 0, 16'h1, 16'h1);
        // wrap FF -> 00, then not-taken branch while stalled still counts
        cyc("jmpff",     1, 0, 0, 1, 8'hFF, 0, 0, 8'h00, 8'h82, 1, 1, 0, 0, 16'h1, 16'h1);
        cyc("atff",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("ntaken",    1, 1, 0, 0, 8'h00, 1, 0, 8'h77, 8'h00, 1, 0, 0, 0, 16'h1, 16'h1);
        cyc("after_nt",  1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'h2, 16'h1);
        // halt at 05, then jump/branch pulses must be ignored
        cyc("jmp05",     1, 0, 0, 1, 8'h05, 0, 0, 8'h00, 8'h01, 1, 1, 0, 0, 16'h2, 16'h1);
        cyc("halt",      1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h05, 1, 0, 0, 0, 16'h2, 16'h1);
        for (int i = 0; i < 10; i++)
            cyc("halted",  1, 0, 0, i[0], 8'h40, ~i[0], 1, 8'h50, 8'h05, 0, 0, 0, 1, 16'h2, 16'h1);
        // reset mid-cycle: checked before the next rising edge
        cyc("async_rst", 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0, 16'h0);
        cyc("boot2",     1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0, 16'h0);
        cyc("run2_0",    1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'h0, 16'h0);
        // preload 65534 taken branches (branch back to 00 each time)
        for (int i = 0; i < 65534; i++)
            drv(1, 0, 0, 0, 8'h00, 1, 1, 8'h00);
        cyc("cnt_fffe",  1, 0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 1, 0, 16'hFFFE, 16'hFFFE);
        cyc("cnt_ffff",  1, 0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 1, 0, 16'hFFFF, 16'hFFFF);
        cyc("sat1",      1, 0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 1, 0, 16'hFFFF, 16'hFFFF);
        cyc("sat2",      1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);
        cyc("sat3",      1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF);
        // let the monitor drain, bounded
        for (int k = 0; k < 5 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
